// File: rtl/idu_is_miq_sel.sv
// idu_is_miq_sel: MIQ select/issue stage.
// Each cycle it picks the oldest valid, operand-ready MIQ entry, where age is
// measured from the ROB head with modulo wrap. It pulses a one-hot issue_vld
// so that entry is freed. The picked instruction goes into a one-deep issue
// register that drains to register read over a valid/ready handshake.
// Optional feature macro: IDU_IS_MIQ_SEL_PERF_EN adds issue/stall counters.
module idu_is_miq_sel #(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned IID_W     = 5,
  parameter int unsigned PREG_W    = 6
) (
  input  logic                        clk,
  input  logic                        rst_clk,
  input  logic                        rtu_global_flush,
  input  logic [IID_W-1:0]            rtu_idu_rob_head_iid,
  input  logic [ENTRY_NUM-1:0]        ent_vld,
  input  logic [ENTRY_NUM-1:0]        ent_ready,
  input  logic [ENTRY_NUM*IID_W-1:0]  ent_iid,
  input  logic [ENTRY_NUM*7-1:0]      ent_opcode,
  input  logic [ENTRY_NUM*7-1:0]      ent_funct7,
  input  logic [ENTRY_NUM*3-1:0]      ent_funct3,
  input  logic [ENTRY_NUM-1:0]        ent_psrc1_vld,
  input  logic [ENTRY_NUM-1:0]        ent_psrc2_vld,
  input  logic [ENTRY_NUM-1:0]        ent_pdst_vld,
  input  logic [ENTRY_NUM*PREG_W-1:0] ent_psrc1,
  input  logic [ENTRY_NUM*PREG_W-1:0] ent_psrc2,
  input  logic [ENTRY_NUM*PREG_W-1:0] ent_pdst,
  output logic [ENTRY_NUM-1:0]        issue_vld,
  input  logic                        rf_is_ready,
  output logic                        is_rf_vld,
  output logic [IID_W-1:0]            is_rf_iid,
  output logic [6:0]                  is_rf_opcode,
  output logic [6:0]                  is_rf_funct7,
  output logic [2:0]                  is_rf_funct3,
  output logic                        is_rf_psrc1_vld,
  output logic [PREG_W-1:0]           is_rf_psrc1,
  output logic                        is_rf_psrc2_vld,
  output logic [PREG_W-1:0]           is_rf_psrc2,
  output logic                        is_rf_pdst_vld,
  output logic [PREG_W-1:0]           is_rf_pdst,
`ifdef IDU_IS_MIQ_SEL_PERF_EN
  output logic [31:0]                 perf_issue_cnt,
  output logic [31:0]                 perf_stall_cnt,
`endif
  output logic                        miq_sel_stall
);

  typedef struct packed {
    logic [IID_W-1:0]  iid;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic              psrc1_vld;
    logic [PREG_W-1:0] psrc1;
    logic              psrc2_vld;
    logic [PREG_W-1:0] psrc2;
    logic              pdst_vld;
    logic [PREG_W-1:0] pdst;
  } is_fields_t;

  logic [ENTRY_NUM-1:0] cand;
  logic [ENTRY_NUM-1:0] win_oh;
  logic [IID_W-1:0]     age;
  logic [IID_W-1:0]     win_age;
  is_fields_t           win_f;
  logic                 any_cand;
  logic                 can_take;
  logic                 do_issue;

  logic                 is_vld_q;
  logic                 is_vld_d;
  is_fields_t           is_q;
  is_fields_t           is_d;

  // Oldest-ready pick: strict less-than while scanning upward keeps the
  // lowest index on equal ages. The winner's fields are captured in the same pass.
  always_comb begin
    cand    = ent_vld & ent_ready;
    win_oh  = '0;
    win_age = '0;
    age     = '0;
    win_f   = '0;
    for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
      age = ent_iid[k*IID_W +: IID_W] - rtu_idu_rob_head_iid;
      if (cand[k] && ((win_oh == '0) || (age < win_age))) begin
        win_oh          = '0;
        win_oh[k]       = 1'b1;
        win_age         = age;
        win_f.iid       = ent_iid[k*IID_W +: IID_W];
        win_f.opcode    = ent_opcode[k*7 +: 7];
        win_f.funct7    = ent_funct7[k*7 +: 7];
        win_f.funct3    = ent_funct3[k*3 +: 3];
        win_f.psrc1_vld = ent_psrc1_vld[k];
        win_f.psrc1     = ent_psrc1[k*PREG_W +: PREG_W];
        win_f.psrc2_vld = ent_psrc2_vld[k];
        win_f.psrc2     = ent_psrc2[k*PREG_W +: PREG_W];
        win_f.pdst_vld  = ent_pdst_vld[k];
        win_f.pdst      = ent_pdst_vld[k] ? ent_pdst[k*PREG_W +: PREG_W] : '0;
      end
    end
  end

  // Issue/stall decision; both outputs are forced quiet while reset is held.
  always_comb begin
    any_cand      = |cand;
    can_take      = ~is_vld_q | rf_is_ready;
    do_issue      = any_cand & can_take & ~rtu_global_flush & ~rst_clk;
    issue_vld     = do_issue ? win_oh : '0;
    miq_sel_stall = any_cand & ~can_take & ~rtu_global_flush & ~rst_clk;
  end

  // Issue register next state: flush, then load, then drain, else hold.
  always_comb begin
    is_vld_d = is_vld_q;
    is_d     = is_q;
    if (rtu_global_flush) begin
      is_vld_d = 1'b0;
      is_d     = '0;
    end else if (do_issue) begin
      is_vld_d = 1'b1;
      is_d     = win_f;
    end else if (rf_is_ready && is_vld_q) begin
      is_vld_d = 1'b0;
    end
  end

  // Issue register state.
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      is_vld_q <= 1'b0;
      is_q     <= '0;
    end else begin
      is_vld_q <= is_vld_d;
      is_q     <= is_d;
    end
  end

  assign is_rf_vld       = is_vld_q;
  assign is_rf_iid       = is_q.iid;
  assign is_rf_opcode    = is_q.opcode;
  assign is_rf_funct7    = is_q.funct7;
  assign is_rf_funct3    = is_q.funct3;
  assign is_rf_psrc1_vld = is_q.psrc1_vld;
  assign is_rf_psrc1     = is_q.psrc1;
  assign is_rf_psrc2_vld = is_q.psrc2_vld;
  assign is_rf_psrc2     = is_q.psrc2;
  assign is_rf_pdst_vld  = is_q.pdst_vld;
  assign is_rf_pdst      = is_q.pdst;

`ifdef IDU_IS_MIQ_SEL_PERF_EN
  logic [31:0] perf_issue_q;
  logic [31:0] perf_stall_q;

  // Free-running event counters; flush leaves them untouched.
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (do_issue)      perf_issue_q <= perf_issue_q + 32'd1;
      if (miq_sel_stall) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
